ins_frame_parser: RTL and testbench

//  Parametrised successor of the instruction/data head detector on the DMA AXI-stream input FIFO.

---
 rtl/ins_frame_parser.sv | 233 +++++++++++++++++++++++
 tb/tb_ins_frame_parser.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_frame_parser.sv
// ins_frame_parser
//   Frame head detector for the DMA AXI-stream input FIFO.
//   A frame starts with HEAD_WORDS header words. When all of them equal the
//   same head value, the frame is classified as one of:
//     - INST  : the next INST_WORDS config words fill a shadow register,
//               which is copied to instr_code in one step at frame end.
//     - DAT0  : the ifmap store pops the FIFO directly until fifo_last.
//     - DAT1  : the weight store pops the FIFO directly until fifo_last.
//   Unknown heads are drained to fifo_last. Short frames abort to IDLE.
//   Both cases pulse hdr_err and bump the saturating err_cnt.
//
//   Optional build macro: STRB_CHECK_EN. When it is defined, a header or
//   config word accepted with partial byte strobes is treated as an error.
//   When it is undefined, fifo_strb_din is ignored.
//
//   Handshake: the FIFO is first-word-fall-through. A word moves only in a
//   cycle where fifo_read_dout and fifo_empty_n_din are both 1. All word
//   counting and all state changes driven by data use those accepted words
//   only. The store side sees the same rule through dsN_empty_n and dsN_read.
//
//   state_dbg exposes the FSM state:
//     0 IDLE, 1 HEAD, 2 CHEK, 3 INST, 4 DAT0, 5 DAT1, 6 DRAIN
module ins_frame_parser #(
  parameter int          TBITS      = 64,
  parameter int          TBYTE      = TBITS / 8,
  parameter int          HEAD_WORDS = 2,
  parameter int          INST_WORDS = 3,
  parameter logic [63:0] INST_HEAD  = 64'hefef123abbeeff22,
  parameter logic [63:0] DAT0_HEAD  = 64'hefef6543dadaff11,
  parameter logic [63:0] DAT1_HEAD  = 64'hefef6543dadaff22
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TBITS-1:0]         fifo_data_din,
  input  logic [TBYTE-1:0]         fifo_strb_din,
  input  logic                     fifo_last_din,
  input  logic                     fifo_empty_n_din,
  output logic                     fifo_read_dout,
  output logic                     ds0_empty_n,
  input  logic                     ds0_read,
  output logic                     ds1_empty_n,
  input  logic                     ds1_read,
  output logic [TBITS-1:0]         ds_data,
  output logic                     ds_last,
  output logic [INST_WORDS*64-1:0] instr_code,
  output logic                     instr_valid,
  output logic                     start_reg,
  output logic                     hdr_err,
  output logic [7:0]               err_cnt,
  output logic [2:0]               state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HEAD  = 3'd1;
  localparam logic [2:0] S_CHEK  = 3'd2;
  localparam logic [2:0] S_INST  = 3'd3;
  localparam logic [2:0] S_DAT0  = 3'd4;
  localparam logic [2:0] S_DAT1  = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;

  localparam logic [2:0] HEAD_LAST = 3'(HEAD_WORDS - 1);
  localparam logic [2:0] INST_LAST = 3'(INST_WORDS - 1);

  logic [2:0]                 state;
  logic [2:0]                 state_nxt;
  logic [2:0]                 hcnt;
  logic [2:0]                 icnt;
  logic [HEAD_WORDS*64-1:0]   hdr_sr;
  logic [INST_WORDS*64-1:0]   shadow;
  logic [INST_WORDS*64-1:0]   commit_code;
  logic [63:0]                word;
  logic                       accept;
  logic                       strb_bad;
  logic                       all_inst;
  logic                       all_dat0;
  logic                       all_dat1;
  logic                       err_now;
  logic                       commit_now;

  assign word = fifo_data_din[63:0];

`ifdef STRB_CHECK_EN
  assign strb_bad = ~(&fifo_strb_din);
`else
  // Strobes are not checked in this build. The reduction keeps the port
  // referenced, and the AND with 0 removes it from the logic.
  assign strb_bad = 1'b0 & ~(&fifo_strb_din);
`endif

  // Store side: a pass-through of the FIFO head, gated per channel.
  assign ds_data     = fifo_data_din;
  assign ds_last     = fifo_last_din;
  assign ds0_empty_n = (state == S_DAT0) & fifo_empty_n_din;
  assign ds1_empty_n = (state == S_DAT1) & fifo_empty_n_din;
  assign start_reg   = instr_code[63];
  assign state_dbg   = state;
  assign accept      = fifo_read_dout & fifo_empty_n_din;

  // Pop source: the parser pops in header, config and drain states, and the
  // active store pops in the data states.
  always_comb begin
    fifo_read_dout = 1'b0;
    case (state)
      S_HEAD, S_INST, S_DRAIN: fifo_read_dout = fifo_empty_n_din;
      S_DAT0:                  fifo_read_dout = ds0_read;
      S_DAT1:                  fifo_read_dout = ds1_read;
      default:                 fifo_read_dout = 1'b0;
    endcase
  end

  // Header match: every captured header word must equal the same head value.
  always_comb begin
    all_inst = 1'b1;
    all_dat0 = 1'b1;
    all_dat1 = 1'b1;
    for (int k = 0; k < HEAD_WORDS; k++) begin
      all_inst = all_inst & (hdr_sr[k*64 +: 64] == INST_HEAD);
      all_dat0 = all_dat0 & (hdr_sr[k*64 +: 64] == DAT0_HEAD);
      all_dat1 = all_dat1 & (hdr_sr[k*64 +: 64] == DAT1_HEAD);
    end
  end

  // Commit image: the shadow words collected so far, plus the word being
  // accepted now, placed in its own slot.
  always_comb begin
    commit_code = shadow;
    for (int k = 0; k < INST_WORDS; k++) begin
      if (icnt == 3'(k)) commit_code[k*64 +: 64] = word;
    end
  end

  // Next-state logic, with the error and commit events for this cycle.
  always_comb begin
    state_nxt  = state;
    err_now    = 1'b0;
    commit_now = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_empty_n_din) state_nxt = S_HEAD;
      end
      S_HEAD: begin
        if (accept) begin
          if (fifo_last_din) begin
            err_now   = 1'b1;
            state_nxt = S_IDLE;
          end else if (strb_bad) begin
            err_now   = 1'b1;
            state_nxt = S_DRAIN;
          end else if (hcnt == HEAD_LAST) begin
            state_nxt = S_CHEK;
          end
        end
      end
      S_CHEK: begin
        if (all_inst)      state_nxt = S_INST;
        else if (all_dat0) state_nxt = S_DAT0;
        else if (all_dat1) state_nxt = S_DAT1;
        else begin
          err_now   = 1'b1;
          state_nxt = S_DRAIN;
        end
      end
      S_INST: begin
        if (accept) begin
          if (strb_bad) begin
            err_now   = 1'b1;
            state_nxt = fifo_last_din ? S_IDLE : S_DRAIN;
          end else if (icnt == INST_LAST) begin
            commit_now = 1'b1;
            state_nxt  = S_IDLE;
          end else if (fifo_last_din) begin
            err_now   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_DAT0, S_DAT1, S_DRAIN: begin
        if (accept && fifo_last_din) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, status pulses and the saturating error counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      hdr_err     <= 1'b0;
      instr_valid <= 1'b0;
      instr_code  <= '0;
      err_cnt     <= 8'd0;
    end else begin
      state       <= state_nxt;
      hdr_err     <= err_now;
      instr_valid <= commit_now;
      if (commit_now) instr_code <= commit_code;
      if (err_now && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Header capture: the count restarts in IDLE, and accepted words shift in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcnt   <= 3'd0;
      hdr_sr <= '0;
    end else if (state == S_IDLE) begin
      hcnt <= 3'd0;
    end else if ((state == S_HEAD) && accept) begin
      hcnt <= hcnt + 3'd1;
      for (int k = HEAD_WORDS - 1; k > 0; k--) begin
        hdr_sr[k*64 +: 64] <= hdr_sr[(k-1)*64 +: 64];
      end
      hdr_sr[63:0] <= word;
    end
  end

  // Config capture into the shadow. The count restarts in CHEK, so a frame
  // that was dropped leaves nothing that a later frame can see.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icnt   <= 3'd0;
      shadow <= '0;
    end else if (state == S_CHEK) begin
      icnt <= 3'd0;
    end else if ((state == S_INST) && accept) begin
      icnt <= icnt + 3'd1;
      for (int k = 0; k < INST_WORDS; k++) begin
        if (icnt == 3'(k)) shadow[k*64 +: 64] <= word;
      end
    end
  end

endmodule

// File: tb/tb_ins_frame_parser.sv
// tb_ins_frame_parser
//   Directed frames fed through a FIFO model. Expected responses are queued
//   when each frame is issued. A negedge monitor pops and compares them when
//   the DUT shows a store pop, an instr_valid pulse or an hdr_err pulse.
module tb_ins_frame_parser;

  localparam logic [63:0] INST_HEAD = 64'hefef123abbeeff22;
  localparam logic [63:0] DAT0_HEAD = 64'hefef6543dadaff11;
  localparam logic [63:0] DAT1_HEAD = 64'hefef6543dadaff22;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [63:0]  fifo_data_din;
  logic [7:0]   fifo_strb_din;
  logic         fifo_last_din;
  logic         fifo_empty_n_din;
  logic         fifo_read_dout;
  logic         ds0_empty_n;
  logic         ds0_read;
  logic         ds1_empty_n;
  logic         ds1_read;
  logic [63:0]  ds_data;
  logic         ds_last;
  logic [191:0] instr_code;
  logic         instr_valid;
  logic         start_reg;
  logic         hdr_err;
  logic [7:0]   err_cnt;
  logic [2:0]   state_dbg;

  ins_frame_parser dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_data_din    (fifo_data_din),
    .fifo_strb_din    (fifo_strb_din),
    .fifo_last_din    (fifo_last_din),
    .fifo_empty_n_din (fifo_empty_n_din),
    .fifo_read_dout   (fifo_read_dout),
    .ds0_empty_n      (ds0_empty_n),
    .ds0_read         (ds0_read),
    .ds1_empty_n      (ds1_empty_n),
    .ds1_read         (ds1_read),
    .ds_data          (ds_data),
    .ds_last          (ds_last),
    .instr_code       (instr_code),
    .instr_valid      (instr_valid),
    .start_reg        (start_reg),
    .hdr_err          (hdr_err),
    .err_cnt          (err_cnt),
    .state_dbg        (state_dbg)
  );

  // Scoreboard state
  logic [72:0]  fq[$];          // {last, strb, data} words waiting in the FIFO model
  logic [65:0]  exp_ds_q[$];    // {channel, last, data}
  logic [191:0] exp_inst_q[$];  // expected instr_code at each instr_valid pulse
  logic [7:0]   exp_err_q[$];   // expected err_cnt at each hdr_err pulse
  int           n_cmp = 0;
  int           n_bad = 0;
  bit           ds_rand = 1'b0;
  bit [1:0]     ds_seen = 2'b00;
  logic         pop_now;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo_outs();
    if (fq.size() > 0) begin
      fifo_empty_n_din = 1'b1;
      {fifo_last_din, fifo_strb_din, fifo_data_din} = fq[0];
    end else begin
      fifo_empty_n_din = 1'b0;
      fifo_last_din    = 1'b0;
      fifo_strb_din    = 8'h00;
      fifo_data_din    = 64'h0;
    end
  endtask

  task automatic push_w(input logic [63:0] d, input logic [7:0] s, input logic l);
    fq.push_back({l, s, d});
  endtask

  task automatic push_ds(input logic ch, input logic [63:0] d, input logic l);
    push_w(d, 8'hFF, l);
    exp_ds_q.push_back({ch, l, d});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if ((fq.size() == 0) && (state_dbg == 3'd0)) break;
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got busy, expected idle within 400 cycles", name);
    end
    repeat (3) @(negedge clk);
  endtask

  // FIFO model and store-side driver: the pop decision is sampled at
  // negedge and applied at the next posedge, and new outputs appear #1 later.
  initial begin
    fifo_empty_n_din = 1'b0;
    fifo_last_din    = 1'b0;
    fifo_strb_din    = 8'h00;
    fifo_data_din    = 64'h0;
    ds0_read         = 1'b0;
    ds1_read         = 1'b0;
    forever begin
      @(negedge clk);
      pop_now = fifo_read_dout && fifo_empty_n_din;
      @(posedge clk);
      if (pop_now && (fq.size() > 0)) void'(fq.pop_front());
      #1;
      drive_fifo_outs();
      ds0_read = ds_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      ds1_read = ds_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the expected queues when the DUT presents a result.
  always @(negedge clk) begin : monitor
    logic [65:0]  e_ds;
    logic [191:0] e_in;
    logic [7:0]   e_er;
    if (reset) begin
      if (ds0_empty_n) ds_seen[0] = 1'b1;
      if (ds1_empty_n) ds_seen[1] = 1'b1;
      if ((ds0_empty_n && ds0_read) || (ds1_empty_n && ds1_read)) begin
        if (exp_ds_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ds_unexpected: got pop of %0h, expected no store pop", ds_data);
        end else begin
          e_ds = exp_ds_q.pop_front();
          check("ds_chan", {191'd0, ds1_empty_n}, {191'd0, e_ds[65]});
          check("ds_last", {191'd0, ds_last}, {191'd0, e_ds[64]});
          check("ds_data", {128'd0, ds_data}, {128'd0, e_ds[63:0]});
        end
      end
      if (instr_valid) begin
        if (exp_inst_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL instr_unexpected: got instr_valid with %0h, expected none", instr_code);
        end else begin
          e_in = exp_inst_q.pop_front();
          check("instr_code", instr_code, e_in);
          check("start_reg", {191'd0, start_reg}, {191'd0, e_in[63]});
        end
      end
      if (hdr_err) begin
        if (exp_err_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL err_unexpected: got hdr_err (err_cnt %0d), expected none", err_cnt);
        end else begin
          e_er = exp_err_q.pop_front();
          check("err_cnt", {184'd0, err_cnt}, {184'd0, e_er});
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [63:0]  wa, wb, wc, wd, we, wf, wg, wh, wi;
    logic [191:0] code_abc;
    logic [191:0] code_def;
    int           n;
    wa = 64'h8000_0000_1111_000A;
    wb = 64'h0123_4567_89AB_CDEF;
    wc = 64'hC0C0_0000_0000_000C;
    wd = 64'h7000_0000_2222_000D;
    we = 64'h0000_0000_3333_000E;
    wf = 64'hFFFF_0000_4444_000F;
    wg = 64'h1111_1111_1111_1111;
    wh = 64'h2222_2222_2222_2222;
    wi = 64'h3333_3333_3333_3333;
    code_abc = {wc, wb, wa};
    code_def = {wf, we, wd};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_instr_code", instr_code, 192'd0);
    check("rst_instr_valid", {191'd0, instr_valid}, 192'd0);
    check("rst_start_reg", {191'd0, start_reg}, 192'd0);
    check("rst_hdr_err", {191'd0, hdr_err}, 192'd0);
    check("rst_err_cnt", {184'd0, err_cnt}, 192'd0);
    check("rst_state", {189'd0, state_dbg}, 192'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: INST frame commits {C,B,A}
    push_w(INST_HEAD, 8'hFF, 1'b0);
    push_w(INST_HEAD, 8'hFF, 1'b0);
    push_w(wa, 8'hFF, 1'b0);
    push_w(wb, 8'hFF, 1'b0);
    push_w(wc, 8'hFF, 1'b1);
    exp_inst_q.push_back(code_abc);
    wait_idle("t1");

    // 2: DAT0 frame with a random ds0_read
    ds_seen = 2'b00;
    ds_rand = 1'b1;
    push_w(DAT0_HEAD, 8'hFF, 1'b0);
    push_w(DAT0_HEAD, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) push_ds(1'b0, 64'hDA7A_0000_0000_0000 | 64'(i), (i == 4));
    wait_idle("t2");
    ds_rand = 1'b0;
    check("t2_ds0_seen", {191'd0, ds_seen[0]}, {191'd0, 1'b1});
    check("t2_ds1_quiet", {191'd0, ds_seen[1]}, 192'd0);

    // 3: mixed head pair is drained
    ds_seen = 2'b00;
    push_w(INST_HEAD, 8'hFF, 1'b0);
    push_w(DAT0_HEAD, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) push_w(64'hBAD0 + 64'(i), 8'hFF, (i == 3));
    exp_err_q.push_back(8'd1);
    wait_idle("t3");
    check("t3_drained", 192'(fq.size()), 192'd0);
    check("t3_no_store", {190'd0, ds_seen}, 192'd0);
    check("t3_instr_kept", instr_code, code_abc);

    // 4: short INST frame
    push_w(INST_HEAD, 8'hFF, 1'b0);
    push_w(INST_HEAD, 8'hFF, 1'b0);
    push_w(64'h5555, 8'hFF, 1'b0);
    push_w(64'h6666, 8'hFF, 1'b1);
    exp_err_q.push_back(8'd2);
    wait_idle("t4");
    check("t4_instr_kept", instr_code, code_abc);
    check("t4_err_cnt", {184'd0, err_cnt}, 192'd2);

    // 5: asynchronous reset in the middle of a DAT1 frame
    push_w(DAT1_HEAD, 8'hFF, 1'b0);
    push_w(DAT1_HEAD, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) push_ds(1'b1, 64'h0D1D_0000_0000_0000 | 64'(i), (i == 7));
    n = 0;
    while ((state_dbg != 3'd5) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_dat1", {189'd0, state_dbg}, 192'd5);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("t5_rst_state", {189'd0, state_dbg}, 192'd0);
    check("t5_rst_ds1", {191'd0, ds1_empty_n}, 192'd0);
    check("t5_rst_read", {191'd0, fifo_read_dout}, 192'd0);
    check("t5_rst_code", instr_code, 192'd0);
    check("t5_rst_start", {191'd0, start_reg}, 192'd0);
    check("t5_rst_errcnt", {184'd0, err_cnt}, 192'd0);
    fq.delete();
    exp_ds_q.delete();
    drive_fifo_outs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_w(INST_HEAD, 8'hFF, 1'b0);
    push_w(INST_HEAD, 8'hFF, 1'b0);
    push_w(wd, 8'hFF, 1'b0);
    push_w(we, 8'hFF, 1'b0);
    push_w(wf, 8'hFF, 1'b1);
    exp_inst_q.push_back(code_def);
    wait_idle("t5");

    // 6: INST frame with partial strobes on its second config word
    push_w(INST_HEAD, 8'hFF, 1'b0);
    push_w(INST_HEAD, 8'hFF, 1'b0);
    push_w(wg, 8'hFF, 1'b0);
    push_w(wh, 8'h0F, 1'b0);
    push_w(wi, 8'hFF, 1'b1);
`ifdef STRB_CHECK_EN
    exp_err_q.push_back(8'd1);
    wait_idle("t6");
    check("t6_instr_kept", instr_code, code_def);
    check("t6_err_cnt", {184'd0, err_cnt}, 192'd1);
`else
    exp_inst_q.push_back({wi, wh, wg});
    wait_idle("t6");
    check("t6_instr_commit", instr_code, {wi, wh, wg});
    check("t6_err_cnt", {184'd0, err_cnt}, 192'd0);
`endif
    check("t6_drained", 192'(fq.size()), 192'd0);

    // Every queued expectation must have been met.
    check("end_ds_q", 192'(exp_ds_q.size()), 192'd0);
    check("end_inst_q", 192'(exp_inst_q.size()), 192'd0);
    check("end_err_q", 192'(exp_err_q.size()), 192'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
